// File: rtl/seq_10100_tx_pkg.sv
// Shared definitions for the 10100 pattern family: state encoding and default sequence,
// so detector and transmitter agree on what is being sent.
package seq_10100_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DONE = 2'b10
  } tx_state_e;

  localparam int unsigned DEFAULT_LEN = 5;
  localparam logic [DEFAULT_LEN-1:0] DEFAULT_PATTERN = 5'b10100;

  // Width of a down-counter indexing LEN bits; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/seq_tx_shift.sv
// Loadable MSB-first shift register; msb is the next bit to be presented on the line.
module seq_tx_shift
  import seq_10100_tx_pkg::*;
#(
  parameter int unsigned LEN = DEFAULT_LEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           shift,
  input  logic [LEN-1:0] load_val,
  output logic           msb
);

  logic [LEN-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_val;
    end else if (shift) begin
      sreg <= {sreg[LEN-2:0], 1'b0};
    end
  end

  assign msb = sreg[LEN-1];

endmodule

// File: rtl/seq_10100_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first, repeated back-to-back reps times,
// with registered busy/valid/done handshake.
module seq_10100_tx
  import seq_10100_tx_pkg::*;
#(
  parameter int unsigned    LEN        = DEFAULT_LEN,
  parameter logic [LEN-1:0] PATTERN    = DEFAULT_PATTERN,
  parameter int unsigned    CNT_W      = 4,
  parameter logic           IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             x_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned       IDX_W    = idx_width(LEN);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(LEN - 1);
  // The first bit goes straight to x_out, so the shifter holds the remainder of the frame.
  localparam logic [LEN-1:0]    RELOAD   = {PATTERN[LEN-2:0], 1'b0};

  tx_state_e        state;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] reps;
  logic             sreg_msb;
  logic             last_bit;
  logic             last_rep;
  logic             accept;
  logic             rewind;
  logic             advance;

  assign last_bit = (bit_idx == '0);
  assign last_rep = (reps == CNT_W'(1));
  assign accept   = (state == ST_IDLE) && start;
  assign rewind   = (state == ST_SEND) && last_bit && !last_rep;
  assign advance  = (state == ST_SEND) && !last_bit;

  seq_tx_shift #(
    .LEN (LEN)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept || rewind),
    .shift    (advance),
    .load_val (RELOAD),
    .msb      (sreg_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      reps    <= '0;
      x_out   <= IDLE_LEVEL;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          x_out <= IDLE_LEVEL;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            state   <= ST_SEND;
            reps    <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
            bit_idx <= IDX_LAST;
            x_out   <= PATTERN[LEN-1];
            valid   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_SEND: begin
          valid <= 1'b1;
          busy  <= 1'b1;
          done  <= 1'b0;
          if (!last_bit) begin
            bit_idx <= bit_idx - 1'b1;
            x_out   <= sreg_msb;
          end else if (!last_rep) begin
            // Next repetition starts on the very next cycle with no gap.
            reps    <= reps - 1'b1;
            bit_idx <= IDX_LAST;
            x_out   <= PATTERN[LEN-1];
          end else begin
            state   <= ST_DONE;
            bit_idx <= '0;
            reps    <= '0;
            x_out   <= IDLE_LEVEL;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          x_out <= IDLE_LEVEL;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          bit_idx <= '0;
          reps    <= '0;
          x_out   <= IDLE_LEVEL;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_10100_tx.md
Name: seq_10100_tx

Overview:
- Serial pattern transmitter: the stimulus-side counterpart of the overlapping 10100 Moore detector.
- On a start request it drives the 5-bit pattern MSB-first on a single serial line, one bit per clock, repeated back-to-back a programmable number of times.
- Used to drive detector-family FSMs in loopback.
- Reports progress with a busy/valid/done handshake.

Parameters:
- PATTERN, 5'b10100, bit pattern to transmit, MSB sent first.
- LEN, 5, pattern length in bits; must equal the width of PATTERN (2..16).
- CNT_W, 4, width of the repeat-count input.
- IDLE_LEVEL, 1'b0, level driven on x_out when not transmitting.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a burst; sampled only in IDLE.
- repeat_n  input  CNT_W  number of pattern repetitions; sampled with start; 0 is treated as 1.
- x_out  output  1  serial data, registered.
- valid  output  1  high on every cycle x_out carries a pattern bit.
- busy  output  1  high from the cycle after start is accepted until done is asserted.
- done  output  1  single-cycle pulse after the last bit of the last repetition.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst is high, regardless of clk:
  - state=IDLE, x_out=IDLE_LEVEL, valid=0, busy=0, done=0.
  - bit index and repeat counter are cleared.
- Reset mid-burst aborts immediately with no done pulse. The first start after rst deasserts is accepted normally.
- All outputs are registered (Moore); no combinational path from inputs to outputs.
- States:
  - IDLE:
    - start=1 at edge N → load shift register with PATTERN, load reps = (repeat_n==0 ? 1 : repeat_n), bit index=LEN-1, go to SEND.
    - start=0 → stay in IDLE.
  - SEND:
    - Each edge presents PATTERN[bit index] on x_out with valid=1, busy=1.
    - The first bit (PATTERN[LEN-1]) appears after edge N: latency 1 cycle from start.
    - On bit 0: if reps>1, decrement reps, reload bit index=LEN-1, stay in SEND. Repetitions are back-to-back with no gap cycle, so overlapping detection across frames is exercised.
    - On bit 0 with reps==1 → go to DONE.
  - DONE:
    - One cycle with done=1, valid=0, busy=0, x_out=IDLE_LEVEL.
    - Next state is IDLE unconditionally.
    - start during DONE is ignored.
- start while busy (SEND) or in DONE is ignored. No queuing and no restart.
- repeat_n is sampled only at acceptance; changes during a burst have no effect.
- Burst length is exactly LEN*reps valid cycles. The earliest next acceptance is at the edge after the done cycle, so min start-to-start spacing is LEN*reps+2 cycles.
- Counters:
  - Bit index width is clog2(LEN).
  - reps width is CNT_W; decrement never wraps because the reload is guarded at reps==1.
- Default state encoding is IDLE=2'b00, SEND=2'b01, DONE=2'b10. An illegal encoding recovers to IDLE on the next edge with outputs at their reset values.

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_SEND, ST_DONE) and the default PATTERN/LEN constants, so the detector and transmitter agree on the sequence.
- One natural sub-module, seq_tx_shift: a loadable LEN-bit MSB-first shift register with load/shift enables. The FSM and counters stay in the top module.

Test Plan:
- Single frame: rst pulse, start=1 one cycle with repeat_n=1 → x_out 1,0,1,0,0 on the next 5 cycles with valid=1 and busy=1; done=1 on the 6th cycle; then idle (x_out=0, valid=0).
- Repeat 3: start with repeat_n=3 → 15 valid cycles carrying 101001010010100, exactly one done pulse, busy high for exactly 15 cycles.
- Zero count: start with repeat_n=0 → identical waveform to repeat_n=1.
- Start while busy: assert start again at bit 2 of a repeat_n=2 burst → burst still totals 10 bits and one done pulse; no restart.
- Async reset mid-burst: raise rst between edges during bit 3 → x_out, valid and busy go to 0 immediately, no done pulse; a start after release yields a clean frame.
- Loopback: drive the overlapping 10100 detector with x_out, burst repeat_n=4 → detector output y asserts exactly 4 times, once per frame end, with no extra hits at frame boundaries.
